// File: rtl/divider_pkg.sv
// Shared state encoding and operand helpers for the sequential divider.
package divider_pkg;

  typedef enum logic [1:0] {StIdle, StCalc, StSign, StDone} div_state_t;

  // Operands arrive zero-extended to 64 bits, so one helper serves any width up to 63.
  function automatic logic div_is_overflow(input logic [63:0] mag_hi, input logic [63:0] d);
    return mag_hi >= d;
  endfunction

  function automatic logic [63:0] div_magnitude(input logic [63:0] z,
                                                input logic signed_mode,
                                                input int unsigned width);
    logic [63:0] mask;
    logic [63:0] top;
    mask = (64'd1 << width) - 64'd1;
    top  = z >> (width - 1);
    if (signed_mode && top[0]) return (~z + 64'd1) & mask;
    return z & mask;
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring division step: shift in a dividend bit, then trial-subtract the divisor.
module divider_step #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] i_rem,
  input  logic         i_bit,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_rem,
  output logic         o_q
);

  logic [W:0]   w_shift;
  logic [W-1:0] w_diff;

  assign w_shift = {i_rem, i_bit};
  // The remainder stays below d, so the true difference always fits in W bits.
  assign w_diff  = w_shift[W-1:0] - i_d;
  assign o_q     = (w_shift >= {1'b0, i_d});
  assign o_rem   = o_q ? w_diff : w_shift[W-1:0];

endmodule

// File: rtl/divider_seq.sv
// Iterative Z_WIDTH/D_WIDTH divider with valid/ready handshakes on both sides.
// Define DIVIDER_SEQ_EARLY_EXIT_EN to skip the CALC phase for overflowing operations.
module divider_seq
  import divider_pkg::*;
#(
  parameter int unsigned Z_WIDTH = 16,
  parameter int unsigned D_WIDTH = Z_WIDTH / 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [Z_WIDTH-1:0] z,
  input  logic [D_WIDTH-1:0] d,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH:0]   q,
  output logic [D_WIDTH:0]   s,
  output logic               div0,
  output logic               ovf,
  output logic               busy
);

  localparam int unsigned CntW = $clog2(D_WIDTH + 1);

  div_state_t r_state, w_state_d;

  logic               r_neg, r_ovf, r_div0;
  logic [D_WIDTH-1:0] r_d, r_rem, r_lo;
  logic [CntW-1:0]    r_cnt;
  logic [D_WIDTH:0]   r_q, r_s;

  logic               w_accept, w_neg, w_ovf, w_q_bit;
  logic [Z_WIDTH-1:0] w_mag;
  logic [D_WIDTH-1:0] w_rem_nxt;
  logic [D_WIDTH:0]   w_qm, w_rm;

  assign in_ready  = (r_state == StIdle) && ena && !rst;
  assign busy      = (r_state != StIdle);
  assign out_valid = (r_state == StDone);
  assign q         = r_q;
  assign s         = r_s;
  assign div0      = r_div0;
  assign ovf       = r_ovf;

  assign w_accept = in_valid && in_ready;
  assign w_neg    = in_signed & z[Z_WIDTH-1];
  assign w_mag    = Z_WIDTH'(div_magnitude(64'(z), in_signed, Z_WIDTH));
  assign w_ovf    = div_is_overflow(64'(w_mag[Z_WIDTH-1:D_WIDTH]), 64'(d));
  assign w_qm     = {1'b0, r_lo};
  assign w_rm     = {1'b0, r_rem};

  // The low dividend half shifts out of r_lo's top while quotient bits fill its bottom.
  divider_step #(
    .W(D_WIDTH)
  ) u_step (
    .i_rem(r_rem),
    .i_bit(r_lo[D_WIDTH-1]),
    .i_d  (r_d),
    .o_rem(w_rem_nxt),
    .o_q  (w_q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else if (ena) begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
`ifdef DIVIDER_SEQ_EARLY_EXIT_EN
          w_state_d = w_ovf ? StSign : StCalc;
`else
          w_state_d = StCalc;
`endif
        end
      end
      StCalc:  if (r_cnt == CntW'(D_WIDTH - 1)) w_state_d = StSign;
      StSign:  w_state_d = StDone;
      StDone:  if (out_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_neg  <= 1'b0;
      r_ovf  <= 1'b0;
      r_div0 <= 1'b0;
      r_d    <= '0;
      r_rem  <= '0;
      r_lo   <= '0;
      r_cnt  <= '0;
      r_q    <= '0;
      r_s    <= '0;
    end else if (ena) begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_neg  <= w_neg;
            r_ovf  <= w_ovf;
            r_div0 <= (d == '0);
            r_d    <= d;
            r_rem  <= w_mag[Z_WIDTH-1:D_WIDTH];
            r_lo   <= w_mag[D_WIDTH-1:0];
            r_cnt  <= '0;
          end
        end
        StCalc: begin
          r_rem <= w_rem_nxt;
          r_lo  <= {r_lo[D_WIDTH-2:0], w_q_bit};
          r_cnt <= r_cnt + CntW'(1);
        end
        StSign: begin
          r_q <= r_ovf ? '0 : (r_neg ? -w_qm : w_qm);
          r_s <= r_ovf ? '0 : (r_neg ? -w_rm : w_rm);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Directed and randomized checks of divider_seq against an integer-arithmetic reference.
module tb_divider_seq;

  localparam int unsigned ZW = 16;
  localparam int unsigned DW = 8;
  localparam int CalcLat = DW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_signed = 1'b0;
  logic          out_ready = 1'b0;
  logic [ZW-1:0] z = '0;
  logic [DW-1:0] d = '0;
  logic          in_ready, out_valid, div0, ovf, busy;
  logic [DW:0]   q, s;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  divider_seq #(
    .Z_WIDTH(ZW),
    .D_WIDTH(DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_signed(in_signed),
    .z        (z),
    .d        (d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .q        (q),
    .s        (s),
    .div0     (div0),
    .ovf      (ovf),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: signed/unsigned integer division, truncating toward zero.
  task automatic model(input logic [15:0] zv, input logic [7:0] dv, input logic sgn,
                       output logic [8:0] eq, output logic [8:0] es,
                       output logic ediv0, output logic eovf, output int elat);
    int zi, mag, qi, si;
    zi    = sgn ? int'($signed(zv)) : int'(zv);
    mag   = (zi < 0) ? -zi : zi;
    ediv0 = (dv == 8'd0);
    eovf  = (mag / 256) >= int'(dv);
    if (eovf) begin
      eq = '0;
      es = '0;
    end else begin
      qi = zi / int'(dv);
      si = zi % int'(dv);
      eq = 9'(qi);
      es = 9'(si);
    end
`ifdef DIVIDER_SEQ_EARLY_EXIT_EN
    elat = eovf ? 1 : CalcLat;
`else
    elat = CalcLat;
`endif
  endtask

  task automatic run_op(input logic [15:0] zv, input logic [7:0] dv, input logic sgn,
                        input int stall_at, input int stall_len, input int hold,
                        input string tag);
    logic [8:0] eq, es;
    logic       ed0, eov;
    int         elat, total;
    model(zv, dv, sgn, eq, es, ed0, eov, elat);
    @(negedge clk);
    check({tag, ":in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; z = zv; d = dv; in_signed = sgn; ena = 1'b1;
    @(posedge clk);
    total = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 0) begin
        // Garbage operands and stray valids while busy must be ignored.
        in_valid  = 1'($urandom_range(0, 1));
        z         = 16'($urandom);
        d         = 8'($urandom);
        in_signed = 1'($urandom_range(0, 1));
      end
      if (out_valid) break;
      ena = (total < stall_at || total >= stall_at + stall_len);
      @(posedge clk);
      total++;
    end
    ena = 1'b1;
    in_valid = 1'b0;
    check({tag, ":latency"}, 32'(total), 32'(elat + stall_len));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, ":hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ":hold_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, ":hold_q"}, 32'(q), 32'(eq));
    end
    check({tag, ":q"}, 32'(q), 32'(eq));
    check({tag, ":s"}, 32'(s), 32'(es));
    check({tag, ":div0"}, 32'(div0), 32'(ed0));
    check({tag, ":ovf"}, 32'(ovf), 32'(eov));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ":valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, ":busy_after"}, 32'(busy), 32'd0);
    check({tag, ":in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int rises;
    repeat (2) @(negedge clk);
    check("rst:out_valid", 32'(out_valid), 32'd0);
    check("rst:q", 32'(q), 32'd0);
    check("rst:s", 32'(s), 32'd0);
    check("rst:div0", 32'(div0), 32'd0);
    check("rst:ovf", 32'(ovf), 32'd0);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;

    run_op(16'd1000, 8'd7, 1'b0, 99, 0, 0, "u1000_7");
    run_op(16'hFC18, 8'd7, 1'b1, 99, 0, 0, "s-1000_7");
    run_op(16'd5, 8'd0, 1'b0, 99, 0, 0, "div0");
    run_op(16'h0800, 8'd8, 1'b0, 99, 0, 0, "ovf_edge");
    run_op(16'h07FF, 8'd8, 1'b0, 99, 0, 0, "no_ovf_edge");
    run_op(16'h8000, 8'd128, 1'b1, 99, 0, 0, "min_ovf");
    run_op(16'h8000, 8'd255, 1'b1, 99, 0, 0, "min_255");
    run_op(16'h8000, 8'd255, 1'b0, 99, 0, 0, "u8000_255");
    run_op(16'd1000, 8'd7, 1'b0, 99, 0, 5, "backpressure");
    run_op(16'd1000, 8'd7, 1'b0, 3, 3, 0, "stall");

    // Reset in the middle of CALC, after four steps.
    @(negedge clk);
    in_valid = 1'b1; z = 16'd1234; d = 8'd50; in_signed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst:busy", 32'(busy), 32'd0);
    check("midrst:out_valid", 32'(out_valid), 32'd0);
    check("midrst:in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst:in_ready_release", 32'(in_ready), 32'd1);
    rises = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) rises++;
    end
    check("midrst:no_valid", 32'(rises), 32'd0);
    run_op(16'd100, 8'd9, 1'b0, 99, 0, 0, "after_rst");

    for (int k = 0; k < 40; k++) begin
      logic [7:0]  rd;
      logic [15:0] rz;
      rd = 8'($urandom);
      rz = 16'($urandom);
      if (k % 2 == 0 && rd != 8'd0) rz[15:8] = 8'($urandom_range(0, int'(rd) - 1));
      run_op(rz, rd, 1'($urandom_range(0, 1)), 99, 0, k % 3, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
